// File: rtl/shift_register_pkg.sv
// Shared types and constants for the shift register driver.
//   state_e   : controller states
//   cnt_width : bits needed to hold values 0..max_val
//   DEF_*     : default WIDTH / CLK_DIV / LSB_FIRST
package shift_register_pkg;

   localparam int unsigned DEF_WIDTH     = 24;
   localparam int unsigned DEF_CLK_DIV   = 5;
   localparam int unsigned DEF_LSB_FIRST = 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_HIGH,
      S_LATCH,
      S_CLR,
      S_DONE
   } state_e;

   // Width of a counter that must represent 0..max_val inclusive.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/shift_register_driver_if.sv
// Control-side handshake bundle of the shift register driver.
//   start, clear, word : requests from the controller
//   ready, busy, done  : status back from the driver
// master = controller side, slave = driver side.
interface shift_register_driver_if #(
   parameter int unsigned WIDTH = shift_register_pkg::DEF_WIDTH
);
   logic             start;
   logic             clear;
   logic [WIDTH-1:0] word;
   logic             ready;
   logic             busy;
   logic             done;

   modport master (
      output start, clear, word,
      input  ready, busy, done
   );

   modport slave (
      input  start, clear, word,
      output ready, busy, done
   );
endinterface

// File: rtl/shift_clk_div.sv
// Reloadable phase timer: counts CLK_DIV cycles per phase.
//   clk, rst_n    : clock, synchronous active-low reset
//   i_reload      : restart the phase (counter <= CLK_DIV-1)
//   o_phase_end_c : high on the last cycle of the current phase
module shift_clk_div
   import shift_register_pkg::*;
#(
   parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_reload,
   output logic o_phase_end_c
);

   localparam int unsigned CNT_W = cnt_width(CLK_DIV);

   logic [CNT_W-1:0] r_cnt;

   // Down-counter; parks at zero rather than wrapping.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_reload) begin
         r_cnt <= CNT_W'(CLK_DIV - 1);
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   assign o_phase_end_c = (r_cnt == '0);

endmodule

// File: rtl/shift_register_driver.sv
// Serial loader for chained latched shift registers (74HC595 class).
// Shifts a WIDTH-bit word out on sclk/sdata, then pulses lclk; also
// runs a clear sequence (srclr_n low, then latch).
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : start/clear/word in, ready/busy/done out (slave modport)
//   sdata      : serial data, stable through each sclk high
//   sclk       : shift clock (external part samples on rising edge)
//   lclk       : storage latch clock, high for CLK_DIV cycles
//   srclr_n    : external register clear, active low
// Optional macro SHIFT_READBACK_EN adds sdin in, rdata/rvalid out: sdin is
// sampled at the end of each sclk high phase, and the captured word is
// published with done at the end of a transfer.
module shift_register_driver
   import shift_register_pkg::*;
#(
   parameter int unsigned WIDTH     = DEF_WIDTH,
   parameter int unsigned CLK_DIV   = DEF_CLK_DIV,
   parameter int unsigned LSB_FIRST = DEF_LSB_FIRST
) (
   input  logic                    clk,
   input  logic                    rst_n,
   shift_register_driver_if.slave  bus,
   output logic                    sdata,
   output logic                    sclk,
   output logic                    lclk,
   output logic                    srclr_n
`ifdef SHIFT_READBACK_EN
   ,
   input  logic                    sdin,
   output logic [WIDTH-1:0]        rdata,
   output logic                    rvalid
`endif
);

   localparam int unsigned BIT_W = cnt_width(WIDTH);
   localparam bit          LSB   = (LSB_FIRST != 0);

   state_e             r_state;
   logic [WIDTH-1:0]   r_shift;
   logic [BIT_W-1:0]   r_bit;
   logic               r_sdata;
   logic               r_sclk;
   logic               r_lclk;
   logic               r_srclr_n;
   logic               r_done;
   logic               r_ready;
   logic               r_busy;

   logic               w_phase_end;
   logic               w_reload;
   logic [WIDTH-1:0]   w_shift_next;
   logic               w_head_word;
   logic               w_head_next;

   // Timer restarts on every phase boundary and is held loaded while idle,
   // so the first phase after acceptance is a full CLK_DIV cycles.
   assign w_reload = (r_state == S_IDLE) || (r_state == S_DONE) || w_phase_end;

   shift_clk_div #(
      .CLK_DIV (CLK_DIV)
   ) u_clk_div (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_reload      (i_reload_w()),
      .o_phase_end_c (w_phase_end)
   );

   function automatic logic i_reload_w();
      return w_reload;
   endfunction

   // The bit presented next always sits at the exit end of r_shift.
   assign w_shift_next = LSB ? (r_shift >> 1) : (r_shift << 1);
   assign w_head_word  = LSB ? bus.word[0]     : bus.word[WIDTH-1];
   assign w_head_next  = LSB ? w_shift_next[0] : w_shift_next[WIDTH-1];

   // Controller: outputs are loaded on the edge that enters each state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_shift   <= '0;
         r_bit     <= '0;
         r_sdata   <= 1'b0;
         r_sclk    <= 1'b0;
         r_lclk    <= 1'b0;
         r_srclr_n <= 1'b1;
         r_done    <= 1'b0;
         r_ready   <= 1'b1;
         r_busy    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.clear) begin
                  r_state   <= S_CLR;
                  r_srclr_n <= 1'b0;
                  r_ready   <= 1'b0;
                  r_busy    <= 1'b1;
               end else if (bus.start) begin
                  r_state <= S_SETUP;
                  r_shift <= bus.word;
                  r_bit   <= '0;
                  r_sdata <= w_head_word;
                  r_ready <= 1'b0;
                  r_busy  <= 1'b1;
               end
            end
            S_SETUP: begin
               if (w_phase_end) begin
                  r_state <= S_HIGH;
                  r_sclk  <= 1'b1;
               end
            end
            S_HIGH: begin
               if (w_phase_end) begin
                  r_sclk <= 1'b0;
                  if (r_bit == BIT_W'(WIDTH - 1)) begin
                     r_state <= S_LATCH;
                     r_lclk  <= 1'b1;
                  end else begin
                     r_state <= S_SETUP;
                     r_shift <= w_shift_next;
                     r_bit   <= r_bit + BIT_W'(1);
                     r_sdata <= w_head_next;
                  end
               end
            end
            S_CLR: begin
               if (w_phase_end) begin
                  r_state   <= S_LATCH;
                  r_srclr_n <= 1'b1;
                  r_lclk    <= 1'b1;
               end
            end
            S_LATCH: begin
               if (w_phase_end) begin
                  r_state <= S_DONE;
                  r_lclk  <= 1'b0;
                  r_sdata <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_ready <= 1'b1;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign sdata     = r_sdata;
   assign sclk      = r_sclk;
   assign lclk      = r_lclk;
   assign srclr_n   = r_srclr_n;
   assign bus.done  = r_done;
   assign bus.ready = r_ready;
   assign bus.busy  = r_busy;

`ifdef SHIFT_READBACK_EN
   logic [WIDTH-1:0] r_cap;
   logic [WIDTH-1:0] r_rdata;
   logic             r_rvalid;
   logic             r_xfer;

   // Capture sdin in transmit order; publish only for shift transfers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cap    <= '0;
         r_rdata  <= '0;
         r_rvalid <= 1'b0;
         r_xfer   <= 1'b0;
      end else begin
         r_rvalid <= 1'b0;
         if (r_state == S_IDLE) begin
            r_xfer <= !bus.clear;
         end
         if ((r_state == S_HIGH) && w_phase_end) begin
            r_cap <= LSB ? {sdin, r_cap[WIDTH-1:1]} : {r_cap[WIDTH-2:0], sdin};
         end
         if ((r_state == S_LATCH) && w_phase_end && r_xfer) begin
            r_rdata  <= r_cap;
            r_rvalid <= 1'b1;
         end
      end
   end

   assign rdata  = r_rdata;
   assign rvalid = r_rvalid;
`endif

endmodule

// File: tb/tb_shift_register_driver.sv
// Bench for shift_register_driver: two instances (LSB-first and MSB-first,
// WIDTH=8, CLK_DIV=2) share one stimulus stream and are each checked
// against timing and bit-order expectations derived from the word.
module tb_shift_register_driver;

   localparam int unsigned TW = 8;
   localparam int unsigned TD = 2;

   logic clk = 1'b0;
   logic rst_n;
   logic tb_start;
   logic tb_clear;
   logic [TW-1:0] tb_word;

   int n_checks = 0;
   int n_fail   = 0;

   shift_register_driver_if #(.WIDTH(TW)) if_a ();
   shift_register_driver_if #(.WIDTH(TW)) if_b ();

   assign if_a.start = tb_start;
   assign if_a.clear = tb_clear;
   assign if_a.word  = tb_word;
   assign if_b.start = tb_start;
   assign if_b.clear = tb_clear;
   assign if_b.word  = tb_word;

   logic sdata_a, sclk_a, lclk_a, srclr_n_a;
   logic sdata_b, sclk_b, lclk_b, srclr_n_b;
`ifdef SHIFT_READBACK_EN
   logic [TW-1:0] rdata_a, rdata_b;
   logic          rvalid_a, rvalid_b;
   logic [TW-1:0] exp_rdata [2];
`endif

   always #5 clk = ~clk;

   shift_register_driver #(.WIDTH(TW), .CLK_DIV(TD), .LSB_FIRST(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(if_a),
      .sdata(sdata_a), .sclk(sclk_a), .lclk(lclk_a), .srclr_n(srclr_n_a)
`ifdef SHIFT_READBACK_EN
      , .sdin(sdata_a), .rdata(rdata_a), .rvalid(rvalid_a)
`endif
   );

   shift_register_driver #(.WIDTH(TW), .CLK_DIV(TD), .LSB_FIRST(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(if_b),
      .sdata(sdata_b), .sclk(sclk_b), .lclk(lclk_b), .srclr_n(srclr_n_b)
`ifdef SHIFT_READBACK_EN
      , .sdin(sdata_b), .rdata(rdata_b), .rvalid(rvalid_b)
`endif
   );

   wire [1:0] v_sdata   = {sdata_b, sdata_a};
   wire [1:0] v_sclk    = {sclk_b, sclk_a};
   wire [1:0] v_lclk    = {lclk_b, lclk_a};
   wire [1:0] v_srclr_n = {srclr_n_b, srclr_n_a};
   wire [1:0] v_ready   = {if_b.ready, if_a.ready};
   wire [1:0] v_busy    = {if_b.busy, if_a.busy};
   wire [1:0] v_done    = {if_b.done, if_a.done};
`ifdef SHIFT_READBACK_EN
   wire [1:0]    v_rvalid = {rvalid_b, rvalid_a};
   logic [TW-1:0] v_rdata [2];
   assign v_rdata[0] = rdata_a;
   assign v_rdata[1] = rdata_b;
`endif

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: order in which word bits must appear on the wire.
   function automatic logic [TW-1:0] exp_order(input logic [TW-1:0] w, input bit lsb);
      logic [TW-1:0] s;
      for (int i = 0; i < int'(TW); i++) s[i] = lsb ? w[i] : w[int'(TW) - 1 - i];
      return s;
   endfunction

   // Called just after the accepting edge; watches the whole operation.
   task automatic observe(input bit is_clr, input logic [TW-1:0] w, input bit hold,
                          input int pulse_at, input string tag);
      int lat, kend;
      int rises[2], lc_cnt[2], lc_first[2], sc_cnt[2], sc_first[2];
      int dn_cnt[2], dn_first[2], ovl[2], chg[2];
      logic [TW-1:0] seq[2];
      logic prev_sclk[2], prev_sdata[2];
`ifdef SHIFT_READBACK_EN
      int rv_cnt[2];
      logic rv_at_done[2];
      logic [TW-1:0] rd_done[2];
`endif
      lat  = is_clr ? 2 * int'(TD) : (2 * int'(TW) + 1) * int'(TD);
      kend = hold ? lat + 1 : lat + 2;
      for (int d = 0; d < 2; d++) begin
         rises[d] = 0; lc_cnt[d] = 0; lc_first[d] = -1; sc_cnt[d] = 0; sc_first[d] = -1;
         dn_cnt[d] = 0; dn_first[d] = -1; ovl[d] = 0; chg[d] = 0; seq[d] = '0;
         prev_sclk[d] = 1'b0; prev_sdata[d] = 1'b0;
`ifdef SHIFT_READBACK_EN
         rv_cnt[d] = 0; rv_at_done[d] = 1'b0; rd_done[d] = '0;
`endif
      end
      for (int k = 0; k <= kend; k++) begin
         @(negedge clk);
         if (k == 0) begin
            tb_clear = 1'b0;
            if (!hold) tb_start = 1'b0;
         end
         if (pulse_at > 0) begin
            if (k == pulse_at) begin
               tb_start = 1'b1;
               tb_word  = ~w;
            end else if (k == pulse_at + 1) begin
               tb_start = 1'b0;
            end
         end
         for (int d = 0; d < 2; d++) begin
            if (v_sclk[d] && !prev_sclk[d]) begin
               if (rises[d] < int'(TW)) seq[d][rises[d]] = v_sdata[d];
               rises[d]++;
            end
            if (v_sclk[d] && prev_sclk[d] && (v_sdata[d] !== prev_sdata[d])) chg[d]++;
            if (v_sclk[d] && v_lclk[d]) ovl[d]++;
            if (v_lclk[d]) begin
               if (lc_first[d] < 0) lc_first[d] = k;
               lc_cnt[d]++;
            end
            if (!v_srclr_n[d]) begin
               if (sc_first[d] < 0) sc_first[d] = k;
               sc_cnt[d]++;
            end
            if (v_done[d]) begin
               if (dn_first[d] < 0) dn_first[d] = k;
               dn_cnt[d]++;
            end
`ifdef SHIFT_READBACK_EN
            if (v_rvalid[d]) rv_cnt[d]++;
            if (k == lat) begin
               rd_done[d]    = v_rdata[d];
               rv_at_done[d] = v_rvalid[d];
            end
`endif
            prev_sclk[d]  = v_sclk[d];
            prev_sdata[d] = v_sdata[d];
         end
         if (k == 0) begin
            chk($sformatf("%s/ready_after_accept", tag), 32'(v_ready), 32'h0);
            chk($sformatf("%s/busy_after_accept", tag), 32'(v_busy), 32'h3);
         end
         if (k == lat) chk($sformatf("%s/ready_at_done", tag), 32'(v_ready), 32'h0);
         if (k == lat + 1) begin
            chk($sformatf("%s/ready_after_done", tag), 32'(v_ready), 32'h3);
            chk($sformatf("%s/busy_after_done", tag), 32'(v_busy), 32'h0);
         end
         if (k == lat + 2) chk($sformatf("%s/still_idle", tag), 32'(v_ready), 32'h3);
         if (k < kend) @(posedge clk);
      end
      for (int d = 0; d < 2; d++) begin
         string t;
         t = $sformatf("%s/%s", tag, (d == 0) ? "lsb" : "msb");
         chk({t, "/sclk_rises"}, 32'(rises[d]), is_clr ? 32'd0 : 32'(TW));
         if (!is_clr)
            chk({t, "/bit_order"}, 32'(seq[d]), 32'(exp_order(w, d == 0)));
         chk({t, "/lclk_cycles"}, 32'(lc_cnt[d]), 32'(TD));
         chk({t, "/lclk_start"}, 32'(lc_first[d]), is_clr ? 32'(TD) : 32'(2 * TW * TD));
         chk({t, "/srclr_cycles"}, 32'(sc_cnt[d]), is_clr ? 32'(TD) : 32'd0);
         if (is_clr) chk({t, "/srclr_start"}, 32'(sc_first[d]), 32'd0);
         chk({t, "/done_pulses"}, 32'(dn_cnt[d]), 32'd1);
         chk({t, "/done_latency"}, 32'(dn_first[d]), 32'(lat));
         chk({t, "/sclk_lclk_overlap"}, 32'(ovl[d]), 32'd0);
         chk({t, "/sdata_glitch_in_high"}, 32'(chg[d]), 32'd0);
`ifdef SHIFT_READBACK_EN
         if (!is_clr) exp_rdata[d] = w;
         chk({t, "/rdata"}, 32'(rd_done[d]), 32'(exp_rdata[d]));
         chk({t, "/rvalid_pulses"}, 32'(rv_cnt[d]), is_clr ? 32'd0 : 32'd1);
         chk({t, "/rvalid_with_done"}, 32'(rv_at_done[d]), is_clr ? 32'd0 : 32'd1);
`endif
      end
   endtask

   // Called at a negedge; waits for idle, requests, then observes.
   task automatic launch(input bit do_start, input bit do_clr, input logic [TW-1:0] w,
                         input bit hold, input int pulse_at, input string tag);
      int guard;
      guard = 0;
      while (v_ready != 2'b11 && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 200) chk({tag, "/idle_timeout"}, 32'(v_ready), 32'h3);
      tb_word  = w;
      tb_start = do_start;
      tb_clear = do_clr;
      @(posedge clk);
      observe(do_clr, w, hold, pulse_at, tag);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int rises, guard, lc, bz;
      logic prev;
      rst_n    = 1'b0;
      tb_start = 1'b1;
      tb_clear = 1'b0;
      tb_word  = 8'hFF;
`ifdef SHIFT_READBACK_EN
      exp_rdata[0] = '0;
      exp_rdata[1] = '0;
`endif
      // Reset held with start asserted: reset must win.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset/ready", 32'(v_ready), 32'h3);
      chk("reset/busy", 32'(v_busy), 32'h0);
      chk("reset/sclk", 32'(v_sclk), 32'h0);
      chk("reset/lclk", 32'(v_lclk), 32'h0);
      chk("reset/srclr_n", 32'(v_srclr_n), 32'h3);
      chk("reset/done", 32'(v_done), 32'h0);
      chk("reset/sdata", 32'(v_sdata), 32'h0);
`ifdef SHIFT_READBACK_EN
      chk("reset/rdata_a", 32'(rdata_a), 32'h0);
      chk("reset/rvalid", 32'(v_rvalid), 32'h0);
`endif
      tb_start = 1'b0;
      rst_n    = 1'b1;
      @(negedge clk);

      launch(1'b1, 1'b0, 8'hA5, 1'b0, -1, "xfer_a5");
      launch(1'b1, 1'b0, 8'h01, 1'b0, -1, "xfer_01");
      launch(1'b1, 1'b0, 8'h3C, 1'b0, -1, "xfer_3c");
      launch(1'b1, 1'b1, 8'hFF, 1'b0, -1, "clear_beats_start");
      launch(1'b1, 1'b0, 8'h96, 1'b0, 5, "busy_pulse");
      launch(1'b1, 1'b0, 8'h81, 1'b1, -1, "held_1");
      launch(1'b1, 1'b0, 8'h7E, 1'b1, -1, "held_2");
      launch(1'b1, 1'b0, 8'hC3, 1'b0, -1, "held_3");

      for (int it = 0; it < 8; it++) begin
         logic [TW-1:0] rw;
         bit rc, rs;
         int pa;
         rw = TW'($urandom);
         rc = ($urandom_range(0, 3) == 0);
         rs = rc ? ($urandom_range(0, 1) == 1) : 1'b1;
         pa = (!rc && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, 30)) : -1;
         repeat ($urandom_range(0, 3)) @(negedge clk);
         launch(rs, rc, rw, 1'b0, pa, $sformatf("rand%0d", it));
      end

      // Abort a transfer with reset during the 5th sclk high.
      tb_word  = 8'h5A;
      tb_start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      tb_start = 1'b0;
      rises = 0;
      guard = 0;
      prev  = 1'b0;
      while (rises < 5 && guard < 200) begin
         if (sclk_a && !prev) rises++;
         prev = sclk_a;
         if (rises < 5) begin
            @(negedge clk);
            guard++;
         end
      end
      if (guard >= 200) chk("abort/sclk_timeout", 32'(rises), 32'd5);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("abort/sclk", 32'(v_sclk), 32'h0);
      chk("abort/lclk", 32'(v_lclk), 32'h0);
      chk("abort/ready", 32'(v_ready), 32'h3);
      chk("abort/done", 32'(v_done), 32'h0);
      chk("abort/sdata", 32'(v_sdata), 32'h0);
`ifdef SHIFT_READBACK_EN
      exp_rdata[0] = '0;
      exp_rdata[1] = '0;
      chk("abort/rdata_b", 32'(rdata_b), 32'h0);
`endif
      rst_n = 1'b1;
      lc = 0;
      bz = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (v_lclk != 2'b00) lc++;
         if (v_busy != 2'b00) bz++;
      end
      chk("abort/no_latch_after", 32'(lc), 32'd0);
      chk("abort/stays_idle", 32'(bz), 32'd0);

      launch(1'b1, 1'b0, 8'hE7, 1'b0, -1, "after_abort");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/shift_register_driver.md
Name: shift_register_driver

Overview:
Parametrised serial loader for external latched shift registers such as chained 74HC595-class parts.
- Accepts a WIDTH-bit word with a start/ready handshake.
- Generates sclk/sdata for WIDTH bits at a programmable rate, then a latch pulse on lclk.
- Provides an explicit clear sequence for the external register.
- Sits between control logic and the board-level register chain, replacing the fixed 24-bit, load-held loader.

Parameters:
WIDTH, 24, bits shifted per transfer (>=2)
CLK_DIV, 5, clk cycles per sclk half-period (>=1); sclk = f_clk/(2*CLK_DIV)
LSB_FIRST, 1, 1 = word[0] shifted first, 0 = word[WIDTH-1] first

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  request transfer; accepted only when ready=1
clear  in  1  request external register clear; accepted only when ready=1
word  in  WIDTH  data captured on the accepting edge
ready  out  1  high in IDLE only
busy  out  1  equals ~ready
done  out  1  one-cycle pulse when a transfer or clear completes
sdata  out  1  serial data to the external register
sclk  out  1  shift clock; the external register samples on its rising edge
lclk  out  1  storage-latch clock, high for CLK_DIV cycles
srclr_n  out  1  external register clear, active low

Behaviour:
- Reset (rst_n=0 at an edge): state IDLE, shift reg 0, bit and div counters 0. Outputs: sdata=0, sclk=0, lclk=0, srclr_n=1, done=0, ready=1. Reset wins over every other event. Reset mid-transfer aborts with no lclk pulse.
- Counters: div counter width $clog2(CLK_DIV+1); bit counter width $clog2(WIDTH+1). Both wrap/reload explicitly; no free-running wrap.
- States: IDLE, SETUP, HIGH, LATCH, CLR, DONE. Each of SETUP, HIGH, LATCH and CLR lasts exactly CLK_DIV cycles.
- IDLE:
  - clear=1 -> CLR. clear beats start when both are asserted.
  - else start=1 -> capture word, bit=0, -> SETUP.
  - start/clear while busy: ignored, not queued.
- SETUP: sclk=0; sdata = current bit (LSB_FIRST selects order) -> HIGH.
- HIGH: sclk=1; sdata held. At the end: bit==WIDTH-1 -> LATCH; else shift by one, bit+1 -> SETUP.
- LATCH: sclk=0, lclk=1, sdata held at last bit -> DONE.
- CLR: srclr_n=0, sclk=0 -> LATCH, so the cleared contents reach the outputs.
- DONE: done=1 for one cycle, lclk=0, sdata=0 -> IDLE. ready rises on the following edge.
- Timing:
  - Transfer latency, accepting edge to done high: (2*WIDTH+1)*CLK_DIV cycles.
  - Clear latency: 2*CLK_DIV cycles.
  - Back-to-back: start held high re-accepts on the first IDLE cycle.
- All outputs are registered; no combinational path from inputs to outputs.
- sclk and lclk are never high simultaneously. sdata is stable for CLK_DIV cycles before and throughout sclk high.

Optional Feature:
- Macro: SHIFT_READBACK_EN.
- When defined:
  - adds input sdin (1) and outputs rdata (WIDTH) and rvalid (1).
  - sdin is sampled on the last clk cycle of each HIGH phase and shifted into a capture register in the same order as transmission.
  - At DONE of a transfer: rdata is updated and rvalid pulses with done. CLR does not update rdata.
  - Reset: rdata=0, rvalid=0.
- When undefined: the ports are absent and the logic is removed. Core timing is identical either way.

Decomposition:
- Package shift_register_pkg holds:
  - the state enum (IDLE, SETUP, HIGH, LATCH, CLR, DONE)
  - the helper function for counter widths
  - the default constants for WIDTH, CLK_DIV and LSB_FIRST
- Natural sub-module: shift_clk_div, a reloadable CLK_DIV down-counter that produces a phase-end strobe. The FSM and datapath stay in the top module.

Test Plan:
- WIDTH=8, CLK_DIV=2, LSB_FIRST=1, start with word=8'hA5 -> sdata at the 8 sclk rising edges = 1,0,1,0,0,1,0,1; lclk high 2 cycles; done at accept+34 cycles; ready high at accept+35.
- Same transfer with LSB_FIRST=0, word=8'hA5 -> sdata sequence 1,0,1,0,0,1,0,1 read MSB first. Also run word=8'h01 -> only the last bit is 1.
- clear and start together in IDLE -> srclr_n low 2 cycles, then lclk high 2 cycles, done at accept+4; no sclk edges; the start is dropped.
- rst_n low at the 5th sclk high during a transfer -> the next edge has sclk=0, lclk=0, ready=1; no lclk pulse ever appears for the aborted word.
- start pulse while busy, and start held continuously -> the pulse is ignored; the held start gives consecutive transfers separated by exactly one IDLE cycle.
- With SHIFT_READBACK_EN, WIDTH=8, sdin loop-driven with 8'h3C -> rdata=8'h3C and rvalid coincide with done.
